// File: rtl/fwd_hazard_if.sv
// Bundle between the ID stage and the forwarding/hazard unit.
// The pipeline side (master) presents the ID instruction fields and the flush.
// The unit side (slave) returns the operand mux selects and the stall and bubble controls.
interface fwd_hazard_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [REG_W-1:0] id_ra;
   logic [REG_W-1:0] id_rb;
   logic             id_ra_used;
   logic             id_rb_used;
   logic [REG_W-1:0] id_rd;
   logic             id_rf_le;
   logic             id_load;
   logic             flush;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic             stall;
   logic             bubble;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_ra, id_rb, id_ra_used, id_rb_used,
             id_rd, id_rf_le, id_load, flush,
      input  fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
   );

   modport slave (
      input  id_valid, id_ra, id_rb, id_ra_used, id_rb_used,
             id_rd, id_rf_le, id_load, flush,
      output fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the ID stage.
// The unit keeps shadow tags {v, rd, le, ld} for EX, MEM and WB. From those tags it selects
// which operand source feeds the ID muxes: 00 register file, 01 EX, 10 MEM, 11 WB.
// On a load-use hazard it holds IF/ID for one cycle and injects a bubble into ID/EX.
module fwd_hazard_unit #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          reset,
   fwd_hazard_if.slave   bus
);

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] rd;
      logic             le;
      logic             ld;
   } tag_t;

   tag_t             ex_q, mem_q, wb_q;
   tag_t             ex_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic ex_hit_a, mem_hit_a, wb_hit_a;
   logic ex_hit_b, mem_hit_b, wb_hit_b;
   logic hazard_a, hazard_b, hazard;
   logic bubble_raw;
   logic [1:0] sel_a, sel_b;

   // A stage can supply register x only if it really writes x. r0 is hardwired and is never forwarded.
   function automatic logic writer_hit(input tag_t t, input logic [REG_W-1:0] x);
      return t.v & t.le & (t.rd == x) & (x != '0);
   endfunction

   // Youngest producer wins. A load still in EX cannot forward, so it falls through to the older stages.
   function automatic logic [1:0] pick_sel(input logic used, input logic ex_hit, input logic ex_ld,
                                           input logic mem_hit, input logic wb_hit);
      logic [1:0] s;
      s = 2'b00;
      if (used) begin
         if (ex_hit && !ex_ld) s = 2'b01;
         else if (mem_hit)     s = 2'b10;
         else if (wb_hit)      s = 2'b11;
      end
      return s;
   endfunction

   // Hazard detection, operand selects, and the tag and counter next state.
   always_comb begin
      ex_hit_a   = writer_hit(ex_q,  bus.id_ra);
      mem_hit_a  = writer_hit(mem_q, bus.id_ra);
      wb_hit_a   = writer_hit(wb_q,  bus.id_ra);
      ex_hit_b   = writer_hit(ex_q,  bus.id_rb);
      mem_hit_b  = writer_hit(mem_q, bus.id_rb);
      wb_hit_b   = writer_hit(wb_q,  bus.id_rb);

      hazard_a   = bus.id_ra_used & ex_hit_a & ex_q.ld;
      hazard_b   = bus.id_rb_used & ex_hit_b & ex_q.ld;
      hazard     = bus.id_valid & ~bus.flush & (hazard_a | hazard_b);
      bubble_raw = hazard | bus.flush;

      sel_a = pick_sel(bus.id_ra_used, ex_hit_a, ex_q.ld, mem_hit_a, wb_hit_a);
      sel_b = pick_sel(bus.id_rb_used, ex_hit_b, ex_q.ld, mem_hit_b, wb_hit_b);
      // The source waiting on the load is re-resolved next cycle, so drive a clean 00 now.
      if (hazard && hazard_a) sel_a = 2'b00;
      if (hazard && hazard_b) sel_b = 2'b00;

      ex_d = '0;
      if (!bubble_raw) begin
         ex_d.v  = bus.id_valid;
         ex_d.rd = bus.id_rd;
         ex_d.le = bus.id_rf_le;
         ex_d.ld = bus.id_load;
      end

      cnt_d = cnt_q;
      if (hazard && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   // The stage tags shadow the pipeline. The stall counter saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
         cnt_q <= cnt_d;
      end
   end

   // While reset is held, every output reads as zero regardless of the ID inputs.
   always_comb begin
      bus.fwd_a_sel   = reset ? 2'b00 : sel_a;
      bus.fwd_b_sel   = reset ? 2'b00 : sel_b;
      bus.stall       = reset ? 1'b0  : hazard;
      bus.bubble      = reset ? 1'b0  : bubble_raw;
      bus.stall_count = reset ? '0    : cnt_q;
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit.
// Each driven cycle pushes its hand-computed expected outputs into a queue.
// A monitor on the falling edge pops one entry per driven cycle and compares it with the outputs.
module tb_fwd_hazard_unit;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   fwd_hazard_if #(.REG_W(5), .CNT_W(16)) bus ();

   fwd_hazard_unit #(.REG_W(5), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          id;
      logic [1:0]  a;
      logic [1:0]  b;
      logic        st;
      logic        bu;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   logic sample_en = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   vec_no = 0;

   task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s vec %0d: got %0h expected %0h", nm, id, act, req);
      end
   endtask

   // Monitor: compare one expected entry for each driven cycle.
   always @(negedge clk) begin
      if (sample_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got output with no expected entry, expected a queued entry");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("fwd_a_sel",   e.id, {30'd0, bus.fwd_a_sel}, {30'd0, e.a});
            cmp("fwd_b_sel",   e.id, {30'd0, bus.fwd_b_sel}, {30'd0, e.b});
            cmp("stall",       e.id, {31'd0, bus.stall},     {31'd0, e.st});
            cmp("bubble",      e.id, {31'd0, bus.bubble},    {31'd0, e.bu});
            cmp("stall_count", e.id, {16'd0, bus.stall_count}, {16'd0, e.cnt});
         end
      end
   end

   // Drive one ID cycle and queue what the unit must answer during that cycle.
   task automatic step(input logic rst, input logic v,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic rau, input logic rbu,
                       input logic [4:0] rd, input logic le, input logic ld, input logic fl,
                       input logic [1:0] ea, input logic [1:0] eb,
                       input logic est, input logic ebu, input logic [15:0] ecnt);
      exp_t e;
      @(posedge clk);
      #1;
      reset          = rst;
      bus.id_valid   = v;
      bus.id_ra      = ra;
      bus.id_rb      = rb;
      bus.id_ra_used = rau;
      bus.id_rb_used = rbu;
      bus.id_rd      = rd;
      bus.id_rf_le   = le;
      bus.id_load    = ld;
      bus.flush      = fl;
      vec_no++;
      e.id  = vec_no;
      e.a   = ea;
      e.b   = eb;
      e.st  = est;
      e.bu  = ebu;
      e.cnt = ecnt;
      exp_q.push_back(e);
      sample_en = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bus.id_valid   = 1'b0;
      bus.id_ra      = '0;
      bus.id_rb      = '0;
      bus.id_ra_used = 1'b0;
      bus.id_rb_used = 1'b0;
      bus.id_rd      = '0;
      bus.id_rf_le   = 1'b0;
      bus.id_load    = 1'b0;
      bus.flush      = 1'b0;

      //   rst v  ra  rb  rau rbu rd  le ld fl   a      b     st bu cnt
      // Reset held two cycles, even with a flush requested: everything reads zero.
      step(1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 16'd0);
      step(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);
      // Idle after reset.
      step(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);
      // ADD rd=5, then a consumer: EX forward on A, rb=6 comes from the register file.
      step(0, 1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);
      step(0, 1, 5'd5, 5'd6, 1, 1, 5'd10, 1, 0, 0, 2'b01, 2'b00, 0, 0, 16'd0);
      // rd=5 is in MEM and rd=10 is in EX: both sources resolve independently.
      step(0, 1, 5'd5, 5'd10, 1, 1, 5'd0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 16'd0);
      step(0, 1, 5'd5, 5'd10, 1, 1, 5'd0, 0, 0, 0, 2'b11, 2'b10, 0, 0, 16'd0);
      step(0, 1, 5'd5, 5'd10, 1, 1, 5'd0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 16'd0);
      // r0 producer, then an r0 consumer: never forwarded.
      step(0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);
      step(0, 1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);
      // LDW rd=7, then a consumer of rb=7: one stall cycle, then the data comes from MEM.
      step(0, 1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 0, 2'b00, 2'b00, 0, 0, 16'd0);
      step(0, 1, 5'd2, 5'd7, 1, 1, 5'd8, 1, 0, 0, 2'b00, 2'b00, 1, 1, 16'd0);
      step(0, 1, 5'd2, 5'd7, 1, 1, 5'd8, 1, 0, 0, 2'b00, 2'b10, 0, 0, 16'd1);
      // Two producers of rd=3 back to back: the one in EX wins. rb=8 comes from WB.
      step(0, 1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 2'b00, 2'b00, 0, 0, 16'd1);
      step(0, 1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 2'b00, 2'b00, 0, 0, 16'd1);
      step(0, 1, 5'd3, 5'd8, 1, 1, 5'd0, 0, 0, 0, 2'b01, 2'b11, 0, 0, 16'd1);
      // The same pair with one empty slot in between: MEM wins over WB.
      step(0, 1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 2'b00, 2'b00, 0, 0, 16'd1);
      step(0, 1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 2'b00, 2'b00, 0, 0, 16'd1);
      step(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd1);
      step(0, 1, 5'd3, 5'd0, 1, 0, 5'd0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 16'd1);
      // LDW rd=9, then a flushed consumer of ra=9: the flush wins and the counter does not move.
      step(0, 1, 5'd3, 5'd0, 0, 0, 5'd9, 1, 1, 0, 2'b00, 2'b00, 0, 0, 16'd1);
      step(0, 1, 5'd9, 5'd0, 1, 0, 5'd4, 1, 0, 1, 2'b00, 2'b00, 0, 1, 16'd1);
      // The squashed rd=4 never reached EX. The load is now in MEM.
      step(0, 1, 5'd4, 5'd9, 1, 1, 5'd0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 16'd1);
      // A second load-use stall brings the counter to 2.
      step(0, 1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 0, 2'b00, 2'b00, 0, 0, 16'd1);
      step(0, 1, 5'd2, 5'd7, 1, 1, 5'd8, 1, 0, 0, 2'b00, 2'b00, 1, 1, 16'd1);
      step(0, 1, 5'd2, 5'd7, 1, 1, 5'd8, 1, 0, 0, 2'b00, 2'b10, 0, 0, 16'd2);
      // Reset arrives while a stall is pending: outputs drop at once, and the tags and counter clear.
      step(0, 1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 0, 2'b00, 2'b00, 0, 0, 16'd2);
      step(1, 1, 5'd2, 5'd7, 1, 1, 5'd8, 1, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);
      step(0, 1, 5'd2, 5'd7, 1, 1, 5'd8, 1, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);

      @(posedge clk);
      #1;
      sample_en = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
